seq_mult8: RTL

Sequential 8x8 unsigned shift-and-add multiplier built around the team's existing 8-bit ripple-carry adder. The adder sits directly downstream of this block's operand registers: this block feeds the adder one partial-product addition per clock and consumes its sum and carry-out. It is the first multi-cycle arithmetic unit in the datapath. It presents a start/busy/done handshake to its requester.

---
 rtl/seq_mult8_if.sv | 14 +
 rtl/seq_mult8.sv | 126 ++++++++++++
 2 files changed

// File: rtl/seq_mult8_if.sv
// Requester-side handshake and operand/result bundle for the sequential 8x8 multiplier.
interface seq_mult8_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input product);
  modport slave  (input  start, input  a,    input  b,
                  output busy,  output done, output product);
endinterface

// File: rtl/seq_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one partial-product addition per clock
// through an 8-bit ripple-carry adder, with a start/busy/done handshake.

module rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       co
);
  logic [8:0] carry_s;

  // Ripple the carry bit by bit through eight full adders
  always_comb begin
    carry_s    = 9'h000;
    s          = 8'h00;
    carry_s[0] = cin;
    for (int i = 0; i < 8; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    co = carry_s[8];
  end
endmodule

module seq_mult8 (
  input  logic        clk,
  input  logic        rst_n,
  seq_mult8_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  mcand_r;
  logic [7:0]  acc_r;
  logic [7:0]  mplr_r;
  logic [2:0]  cnt_r;
  logic [15:0] product_r;
  logic        busy_r;
  logic        done_r;

  logic [7:0]  addend_s;
  logic [7:0]  sum_s;
  logic        co_s;

  // Partial product: the multiplicand only when the current multiplier bit is set
  always_comb begin
    if (mplr_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = 8'h00;
    end
  end

  rca8 u_adder (
    .a   (acc_r),
    .b   (addend_s),
    .cin (1'b0),
    .s   (sum_s),
    .co  (co_s)
  );

  // Control FSM and datapath; the carry-out lands in acc[7] after the shift, so nothing is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mcand_r   <= 8'h00;
      acc_r     <= 8'h00;
      mplr_r    <= 8'h00;
      cnt_r     <= 3'd0;
      product_r <= 16'h0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mcand_r <= bus.a;
            mplr_r  <= bus.b;
            acc_r   <= 8'h00;
            cnt_r   <= 3'd0;
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        RUN: begin
          {acc_r, mplr_r} <= {co_s, sum_s, mplr_r[7:1]};
          cnt_r           <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            product_r <= {co_s, sum_s, mplr_r[7:1]};
            state_r   <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
endmodule
